// File: rtl/score_display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : score_display_pkg
//  Description : Shared constants for the score display controller: the
//                active-low seven-segment glyphs (bit order {g,f,e,d,c,b,a}),
//                the blank glyph and the controller FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package score_display_pkg;

  localparam logic [6:0] c_GLYPH_0     = 7'b1000000;
  localparam logic [6:0] c_GLYPH_1     = 7'b1111001;
  localparam logic [6:0] c_GLYPH_2     = 7'b0100100;
  localparam logic [6:0] c_GLYPH_3     = 7'b0110000;
  localparam logic [6:0] c_GLYPH_4     = 7'b0011001;
  localparam logic [6:0] c_GLYPH_5     = 7'b0010010;
  localparam logic [6:0] c_GLYPH_6     = 7'b0000010;
  localparam logic [6:0] c_GLYPH_7     = 7'b1111000;
  localparam logic [6:0] c_GLYPH_8     = 7'b0000000;
  localparam logic [6:0] c_GLYPH_9     = 7'b0010000;
  localparam logic [6:0] c_GLYPH_BLANK = 7'b1111111;

  // BCD digit shown on every position when the score saturates
  localparam logic [3:0] c_BCD_NINE    = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_COMMIT  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/score_display_ctrl_seg7_encode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_encode
//  Description : Combinational BCD digit to active-low seven-segment glyph.
//                Codes 10..15 and an asserted blank request give all-off.
//  Ports       : i_Bcd   - BCD digit 0..9
//                i_Blank - 1 = force the digit dark
//                o_Seg   - active-low segments {g,f,e,d,c,b,a}
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_encode
  import score_display_pkg::*;
(
  input  logic [3:0] i_Bcd,
  input  logic       i_Blank,
  output logic [6:0] o_Seg
);

  always_comb begin
    o_Seg = c_GLYPH_BLANK;
    if (!i_Blank) begin
      case (i_Bcd)
        4'd0:    o_Seg = c_GLYPH_0;
        4'd1:    o_Seg = c_GLYPH_1;
        4'd2:    o_Seg = c_GLYPH_2;
        4'd3:    o_Seg = c_GLYPH_3;
        4'd4:    o_Seg = c_GLYPH_4;
        4'd5:    o_Seg = c_GLYPH_5;
        4'd6:    o_Seg = c_GLYPH_6;
        4'd7:    o_Seg = c_GLYPH_7;
        4'd8:    o_Seg = c_GLYPH_8;
        4'd9:    o_Seg = c_GLYPH_9;
        default: o_Seg = c_GLYPH_BLANK;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/score_display_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : score_display_ctrl
//  Description : Converts a binary score to NUM_DIGITS seven-segment digits
//                with a sequential shift-and-add-3 converter, saturates to
//                all 9s on overflow, optionally blanks leading zeros and can
//                flash the display with a free-running blink phase.
//  Ports       : i_Clk         - system clock, rising edge
//                i_Rst_L       - asynchronous active-low reset
//                i_Score       - unsigned binary score
//                i_Score_Valid - one-cycle strobe: display i_Score
//                i_Blink_En    - level, 1 = flash the display
//                o_Segments    - active-low segments, digit k at [7k+6:7k]
//                o_Busy        - conversion in progress
//                o_Done        - one-cycle pulse when o_Segments updated
//                o_Overflow    - displayed value was saturated
//  Revision    : 1.0 - initial release
// ============================================================================
module score_display_ctrl
  import score_display_pkg::*;
#(
  parameter int NUM_DIGITS    = 2,
  parameter int SCORE_W       = 7,
  parameter int BLANK_LEADING = 1,
  parameter int BLINK_CYCLES  = 12500000
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  input  logic [SCORE_W-1:0]      i_Score,
  input  logic                    i_Score_Valid,
  input  logic                    i_Blink_En,
  output logic [7*NUM_DIGITS-1:0] o_Segments,
  output logic                    o_Busy,
  output logic                    o_Done,
  output logic                    o_Overflow
);

  localparam int          c_BCD_W   = 4 * NUM_DIGITS;
  localparam int          c_SEG_W   = 7 * NUM_DIGITS;
  localparam int          c_CNT_W   = $clog2(SCORE_W);
  localparam int          c_BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam int unsigned c_MAX_VAL = (10 ** NUM_DIGITS) - 1;

  // Reset display is the value 0: a single "0" in digit 0, the rest blank
  // or zero depending on leading-zero blanking.
  function automatic logic [c_SEG_W-1:0] f_rst_seg();
    logic [c_SEG_W-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      v[7*k +: 7] = ((k == 0) || (BLANK_LEADING == 0)) ? c_GLYPH_0 : c_GLYPH_BLANK;
    end
    return v;
  endfunction

  localparam logic [c_SEG_W-1:0] c_RST_SEG = f_rst_seg();

  function automatic logic f_over(input logic [SCORE_W-1:0] v);
    return ({{(32-SCORE_W){1'b0}}, v} > c_MAX_VAL);
  endfunction

  state_t               r_state;
  logic [SCORE_W-1:0]   r_shift;
  logic [c_BCD_W-1:0]   r_bcd;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_pend_load;
  logic                 r_ovf_work;
  logic                 r_pend_valid;
  logic [SCORE_W-1:0]   r_pend_score;
  logic [c_SEG_W-1:0]   r_seg;
  logic                 r_done;
  logic                 r_overflow;
  logic [c_BLINK_W-1:0] r_blink_cnt;
  logic                 r_phase;

  logic [c_BCD_W-1:0]   w_bcd_adj;
  logic [c_BCD_W-1:0]   w_commit_bcd;
  logic [NUM_DIGITS-1:0] w_blank;
  logic [c_SEG_W-1:0]   w_glyph;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    // Add-3 correction applied before each shift
    assign w_bcd_adj[4*k +: 4] = (r_bcd[4*k +: 4] >= 4'd5) ? (r_bcd[4*k +: 4] + 4'd3)
                                                          : r_bcd[4*k +: 4];
    assign w_commit_bcd[4*k +: 4] = r_ovf_work ? c_BCD_NINE : r_bcd[4*k +: 4];

    if (k == 0) begin : g_lsd
      assign w_blank[k] = 1'b0;
    end else begin : g_msd
      // Blank when this digit and every more significant digit is zero
      assign w_blank[k] = (BLANK_LEADING != 0) && (w_commit_bcd[c_BCD_W-1:4*k] == '0);
    end

    seg7_encode u_seg7_encode (
      .i_Bcd   (w_commit_bcd[4*k +: 4]),
      .i_Blank (w_blank[k]),
      .o_Seg   (w_glyph[7*k +: 7])
    );
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_bcd        <= '0;
      r_cnt        <= '0;
      r_pend_load  <= 1'b0;
      r_ovf_work   <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_score <= '0;
      r_seg        <= c_RST_SEG;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_Score_Valid) begin
            r_shift     <= i_Score;
            r_ovf_work  <= f_over(i_Score);
            r_bcd       <= '0;
            r_cnt       <= '0;
            r_pend_load <= 1'b0;
            r_state     <= ST_CONVERT;
          end
        end

        ST_CONVERT: begin
          if (i_Score_Valid) begin
            r_pend_valid <= 1'b1;
            r_pend_score <= i_Score;
          end
          if (r_pend_load) begin
            // First cycle after a commit with a pending strobe: take the
            // pending score in, exactly as IDLE would for a fresh strobe.
            r_shift     <= r_pend_score;
            r_ovf_work  <= f_over(r_pend_score);
            r_bcd       <= '0;
            r_cnt       <= '0;
            r_pend_load <= 1'b0;
            if (!i_Score_Valid) begin
              r_pend_valid <= 1'b0;
            end
          end else begin
            r_bcd   <= (w_bcd_adj << 1) | {{(c_BCD_W-1){1'b0}}, r_shift[SCORE_W-1]};
            r_shift <= r_shift << 1;
            r_cnt   <= r_cnt + 1'b1;
            if (r_cnt == c_CNT_W'(SCORE_W - 1)) begin
              r_state <= ST_COMMIT;
            end
          end
        end

        ST_COMMIT: begin
          r_seg      <= w_glyph;
          r_overflow <= r_ovf_work;
          r_done     <= 1'b1;
          if (i_Score_Valid) begin
            r_pend_valid <= 1'b1;
            r_pend_score <= i_Score;
          end
          if (i_Score_Valid || r_pend_valid) begin
            r_state     <= ST_CONVERT;
            r_pend_load <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (r_blink_cnt == c_BLINK_W'(BLINK_CYCLES - 1)) begin
      r_blink_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  // Blinking only masks the output; the committed value stays in r_seg
  assign o_Segments = (i_Blink_En && r_phase) ? '1 : r_seg;
  assign o_Busy     = (r_state != ST_IDLE);
  assign o_Done     = r_done;
  assign o_Overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_score_display_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_score_display_ctrl
//  Description : Self-checking bench for score_display_ctrl. Three instances
//                (defaults, no leading-zero blanking, 4-cycle blink) share
//                the stimulus and are compared every cycle to a timeline
//                model of the display.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_score_display_ctrl;

  localparam int SW = 7;

  logic          clk;
  logic          rst_n;
  logic [SW-1:0] score;
  logic          score_valid;
  logic          blink_en;

  logic [13:0] seg_a, seg_nb, seg_bl;
  logic        busy_a, busy_nb, busy_bl;
  logic        done_a, done_nb, done_bl;
  logic        ovf_a, ovf_nb, ovf_bl;

  score_display_ctrl u_dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Score(score), .i_Score_Valid(score_valid),
    .i_Blink_En(blink_en), .o_Segments(seg_a), .o_Busy(busy_a), .o_Done(done_a),
    .o_Overflow(ovf_a)
  );

  score_display_ctrl #(.BLANK_LEADING(0)) u_dut_nb (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Score(score), .i_Score_Valid(score_valid),
    .i_Blink_En(blink_en), .o_Segments(seg_nb), .o_Busy(busy_nb), .o_Done(done_nb),
    .o_Overflow(ovf_nb)
  );

  score_display_ctrl #(.BLINK_CYCLES(4)) u_dut_bl (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Score(score), .i_Score_Valid(score_valid),
    .i_Blink_En(blink_en), .o_Segments(seg_bl), .o_Busy(busy_bl), .o_Done(done_bl),
    .o_Overflow(ovf_bl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Timeline model: a conversion accepted at edge n commits at edge n+SW+1;
  // a pending strobe is accepted on the edge after the commit.
  int n_edge = 0;
  int m_blink_edges;
  bit m_active;
  int m_commit_at;
  int m_cur;
  bit m_pend_v;
  int m_pend;
  int m_start_at;
  int m_disp;
  bit m_ovf;
  bit m_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  function automatic logic [13:0] exp_seg(input int val, input bit blank_lead);
    int d0;
    int d1;
    logic [6:0] hi;
    d0 = val % 10;
    d1 = (val / 10) % 10;
    hi = (blank_lead && d1 == 0) ? 7'b1111111 : glyph(d1);
    return {hi, glyph(d0)};
  endfunction

  task automatic model_reset();
    m_blink_edges = 0;
    m_active      = 0;
    m_commit_at   = -1;
    m_cur         = 0;
    m_pend_v      = 0;
    m_pend        = 0;
    m_start_at    = -1;
    m_disp        = 0;
    m_ovf         = 0;
    m_done        = 0;
  endtask

  task automatic model_edge(input bit v, input int s);
    n_edge++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_blink_edges++;
    m_done = 0;
    if (m_active && n_edge == m_commit_at) begin
      m_disp   = (m_cur > 99) ? 99 : m_cur;
      m_ovf    = (m_cur > 99);
      m_done   = 1;
      m_active = 0;
      if (v) begin m_pend_v = 1; m_pend = s; end
      if (m_pend_v) m_start_at = n_edge + 1;
    end else if (m_start_at == n_edge) begin
      m_cur       = m_pend;
      m_active    = 1;
      m_commit_at = n_edge + SW + 1;
      m_start_at  = -1;
      m_pend_v    = v;
      if (v) m_pend = s;
    end else if (m_active) begin
      if (v) begin m_pend_v = 1; m_pend = s; end
    end else if (v) begin
      m_cur       = s;
      m_active    = 1;
      m_commit_at = n_edge + SW + 1;
    end
  endtask

  task automatic check_all();
    bit exp_busy;
    bit phase;
    exp_busy = m_active || (m_start_at > n_edge);
    phase    = ((m_blink_edges / 4) % 2) == 1;
    chk("busy",     busy_a,  exp_busy);
    chk("done",     done_a,  m_done);
    chk("overflow", ovf_a,   m_ovf);
    chk("seg",      seg_a,   exp_seg(m_disp, 1));
    chk("seg_nb",   seg_nb,  exp_seg(m_disp, 0));
    chk("done_bl",  done_bl, m_done);
    chk("seg_bl",   seg_bl,  (blink_en && phase) ? 14'h3FFF : exp_seg(m_disp, 1));
  endtask

  task automatic tick(input logic v, input logic [SW-1:0] s);
    score_valid = v;
    score       = s;
    @(posedge clk);
    model_edge(v, int'(s));
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, '0);
  endtask

  initial begin
    int done_at[$];
    rst_n       = 1'b0;
    score_valid = 1'b0;
    score       = '0;
    blink_en    = 1'b0;
    model_reset();

    idle(3);
    chk("rst_seg",    seg_a,  {7'b1111111, 7'b1000000});
    chk("rst_seg_nb", seg_nb, {7'b1000000, 7'b1000000});
    chk("rst_busy",   busy_a, 1'b0);
    rst_n = 1'b1;
    idle(2);

    // 42: busy for 8 cycles, done 8 edges after acceptance
    tick(1'b1, 7'd42);
    chk("42_busy_first", busy_a, 1'b1);
    idle(7);
    chk("42_busy_last", busy_a, 1'b1);
    chk("42_no_done_early", done_a, 1'b0);
    idle(1);
    chk("42_done", done_a, 1'b1);
    chk("42_busy_after", busy_a, 1'b0);
    chk("42_seg", seg_a, {7'b0011001, 7'b0100100});
    idle(2);

    // 7 then 0, blanking on and off
    tick(1'b1, 7'd7);
    idle(9);
    chk("7_seg",    seg_a,  {7'b1111111, 7'b1111000});
    chk("7_seg_nb", seg_nb, {7'b1000000, 7'b1111000});
    tick(1'b1, 7'd0);
    idle(9);
    chk("0_seg", seg_a, {7'b1111111, 7'b1000000});

    // Saturation and its release
    tick(1'b1, 7'd127);
    idle(9);
    chk("127_seg", seg_a, {7'b0010000, 7'b0010000});
    chk("127_ovf", ovf_a, 1'b1);
    tick(1'b1, 7'd5);
    idle(9);
    chk("5_ovf", ovf_a, 1'b0);

    // 12, 34, 56: newest pending wins, second done 17 edges after first strobe
    done_at.delete();
    tick(1'b1, 7'd12);
    for (int k = 1; k <= 22; k++) begin
      if (k == 2)      tick(1'b1, 7'd34);
      else if (k == 4) tick(1'b1, 7'd56);
      else             tick(1'b0, '0);
      if (done_a) done_at.push_back(k);
      if (k == 8) chk("12_seg", seg_a, {7'b1111001, 7'b0100100});
    end
    chk("pend_commits", done_at.size(), 2);
    if (done_at.size() == 2) begin
      chk("pend_done1", done_at[0], 8);
      chk("pend_done2", done_at[1], 17);
    end
    chk("56_seg", seg_a, {7'b0010010, 7'b0000010});

    // Blink around a committed 88, then a new strobe during blinking
    tick(1'b1, 7'd88);
    idle(10);
    blink_en = 1'b1;
    idle(12);
    done_at.delete();
    tick(1'b1, 7'd33);
    for (int k = 1; k <= 12; k++) begin
      tick(1'b0, '0);
      if (done_bl) done_at.push_back(k);
    end
    chk("blink_commits", done_at.size(), 1);
    if (done_at.size() == 1) chk("blink_latency", done_at[0], 8);
    chk("blink_seg_a", seg_a, {7'b0110000, 7'b0110000});
    blink_en = 1'b0;
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic v;
      logic [SW-1:0] s;
      v = ($urandom_range(0, 5) == 0);
      s = ($urandom_range(0, 2) == 0) ? SW'($urandom_range(0, 9)) : SW'($urandom_range(0, 127));
      if ($urandom_range(0, 39) == 0) blink_en = ~blink_en;
      tick(v, s);
    end
    blink_en = 1'b0;
    idle(25);

    // Reset in the middle of a conversion
    tick(1'b1, 7'd99);
    idle(3);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("midrst_busy", busy_a, 1'b0);
    chk("midrst_seg",  seg_a,  {7'b1111111, 7'b1000000});
    idle(2);
    rst_n = 1'b1;
    done_at.delete();
    for (int k = 0; k < 15; k++) begin
      tick(1'b0, '0);
      if (done_a) done_at.push_back(k);
    end
    chk("midrst_no_done", done_at.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
`default_nettype wire
